rf_dump: RTL and testbench

Register-file readback engine for the RISC-V register file test top. On a start pulse it walks every register through a read port of the register file and streams the contents out as a byte stream over a valid/ready interface, normally into a UART transmitter. It is the readout counterpart to the switch/button write path: registers loaded by hand are dumped here for host-side checking.

---
 rtl/rf_dump_pkg.sv | 15 +
 rtl/rf_dump.sv | 117 +++++++++++
 tb/tb_rf_dump.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file readback engine.
package rf_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] HEADER_BYTE   = 8'hA5;
  localparam int         BYTES_PER_REG = 5;

endpackage

// File: rtl/rf_dump.sv
// Streams 0xA5 then {addr, data[31:24..7:0]} for every register; header valid one cycle after start.
// Each byte holds on tx_data/tx_valid until taken; next byte follows with no bubble.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [DATA_W-1:0] snap, snap_nxt;
  logic              xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
    end
  end

  assign xfer = tx_valid & tx_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    snap_nxt  = snap;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HEADER;
          cnt_nxt   = '0;
        end
      end
      HEADER: begin
        if (xfer) state_nxt = ADDR;
      end
      ADDR: begin
        // Snapshot keeps the four data bytes coherent against concurrent writes.
        if (xfer) begin
          snap_nxt  = rd_data;
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          if (idx == 2'd3) begin
            if (cnt == LAST_REG) begin
              state_nxt = DONE;
            end else begin
              cnt_nxt   = cnt + 1'b1;
              state_nxt = ADDR;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing combinational from tx_ready.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    rd_addr  = cnt;
    case (state)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
      end
      ADDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'(cnt);
      end
      DATA: begin
        tx_valid = 1'b1;
        case (idx)
          2'd0:    tx_data = snap[31:24];
          2'd1:    tx_data = snap[23:16];
          2'd2:    tx_data = snap[15:8];
          default: tx_data = snap[7:0];
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: scoreboard of expected stream bytes checked on every transfer.
module tb_rf_dump;
  import rf_dump_pkg::*;

  localparam int NR     = 32;
  localparam int NBYTES = 1 + BYTES_PER_REG * NR;
  localparam int A_NONE = 0, A_WR = 1, A_START = 2, A_RST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, tx_ready, tx_valid, busy, done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic [31:0] regs [NR];

  logic        start4, tx_valid4, busy4, done4;
  logic [1:0]  rd_addr4;
  logic [31:0] rd_data4;
  logic [7:0]  tx_data4;
  logic [31:0] regs4 [4];

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs4[rd_addr4];

  rf_dump #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  rf_dump #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(1'b1), .busy(busy4), .done(done4)
  );

  int n_checks = 0, n_fail = 0;
  logic [7:0] sb [$];
  int xfer_cnt = 0, done_cnt = 0, cyc = 0, first_cyc = -1, last_cyc = 0, done_cyc = 0;
  bit hold_vld = 1'b0;
  logic [7:0] hold_dat = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        sb.delete();
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(hold_dat));
        end
        if (tx_valid && tx_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("stream_byte", 32'(tx_data), 32'(e));
          end
          xfer_cnt++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
        hold_vld = tx_valid && !tx_ready;
        hold_dat = tx_data;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic push_stream();
    sb.push_back(HEADER_BYTE);
    for (int n = 0; n < NR; n++) begin
      sb.push_back(8'(n));
      sb.push_back(regs[n][31:24]);
      sb.push_back(regs[n][23:16]);
      sb.push_back(regs[n][15:8]);
      sb.push_back(regs[n][7:0]);
    end
  endtask

  task automatic run_dump(input bit rnd, input int act, input int act_at);
    int  x0, d0, n, last_n;
    bit  aborted, finished;
    push_stream();
    x0 = xfer_cnt;
    d0 = done_cnt;
    first_cyc = -1;
    aborted = 1'b0;
    finished = 1'b0;
    last_n = -1;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("hdr_valid", 32'(tx_valid), 32'd1);
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_data", 32'(tx_data), 32'hA5);
    for (int c = 0; c < 2000; c++) begin
      start = 1'b0;
      if (done_cnt != d0) begin
        finished = 1'b1;
        break;
      end
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      n = xfer_cnt - x0;
      if (act == A_WR && n == act_at && last_n != n) regs[5] = 32'hDEAD_BEEF;
      if (act == A_START && (n == act_at || n == NBYTES) && last_n != n) start = 1'b1;
      if (act == A_RST && n == act_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      last_n = n;
      @(posedge clk); #1;
    end
    if (aborted) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("abort_bytes", 32'(xfer_cnt - x0), 32'(act_at));
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_idle", 32'(tx_valid), 32'd0);
    end else begin
      check("dump_timeout", 32'(finished), 32'd1);
      check("byte_count", 32'(xfer_cnt - x0), 32'(NBYTES));
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
      if (!rnd) begin
        check("consecutive", 32'(last_cyc - first_cyc), 32'(NBYTES - 1));
        check("done_latency", 32'(done_cyc - last_cyc), 32'd1);
      end
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("no_restart_valid", 32'(tx_valid), 32'd0);
      check("no_restart_busy", 32'(busy), 32'd0);
    end
  endtask

  function automatic logic [7:0] exp4(input int i);
    int k, p;
    if (i == 0) return HEADER_BYTE;
    k = (i - 1) / 5;
    p = (i - 1) % 5;
    if (p == 0) return 8'(k);
    return 8'(regs4[k] >> (8 * (4 - p)));
  endfunction

  initial begin
    int idx4, d4, last4, done4_at, c4;
    reset_n  = 1'b0;
    start    = 1'b0;
    start4   = 1'b0;
    tx_ready = 1'b0;
    for (int n = 0; n < NR; n++) regs[n] = 32'h1000_0000 + 32'(n);
    for (int n = 0; n < 4; n++) regs4[n] = 32'hC0DE_0000 + 32'(n * 17);
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_dump(1'b0, A_NONE, 0);
    run_dump(1'b1, A_NONE, 0);
    run_dump(1'b1, A_WR, 27);
    run_dump(1'b0, A_NONE, 0);
    run_dump(1'b0, A_START, 40);
    run_dump(1'b0, A_RST, 73);
    run_dump(1'b0, A_NONE, 0);

    idx4 = 0;
    d4 = 0;
    last4 = 0;
    done4_at = 0;
    c4 = 0;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      c4++;
      if (tx_valid4) begin
        check("r4_byte", 32'(tx_data4), 32'(exp4(idx4)));
        idx4++;
        last4 = c4;
      end
      if (done4) begin
        d4++;
        done4_at = c4;
      end
    end
    check("r4_count", 32'(idx4), 32'd21);
    check("r4_done_pulses", 32'(d4), 32'd1);
    check("r4_done_latency", 32'(done4_at - last4), 32'd1);
    check("r4_idle", 32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
